skew_loader: RTL

- Upstream feeder for the skew buffer. Accepts a stream of signed elements over a valid/ready handshake, in row-major order, one element per handshake.
- Packs each group of ARRAY_SIZE elements into a row and writes it to the skew buffer with the row index.
- After a full ARRAY_SIZE x ARRAY_SIZE tile is written, drives the skew buffer enable for a fixed drain window. Honours a downstream stall, then signals tile completion.

---
 rtl/skew_loader.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/skew_loader.sv
// Packs a row-major signed element stream into rows for the skew buffer, then drives a drain window per tile.
// Latency: a row write appears 1 cycle after its last element; tile_done comes DRAIN_CYCLES enabled cycles after LAST_WR.
// Backpressure: in_ready drops from tile completion to tile_done; stall holds off sb_enable (registered, 1-cycle delay).
//
// Ports:
//   clk, rst         clock; synchronous active-low reset
//   in_valid/in_ready/in_data   element handshake (signed DATA_WIDTH)
//   in_last          only with SKEW_LOADER_PAD_EN: zero-pad the rest of the tile
//   stall            downstream stall, suppresses sb_enable
//   sb_write/sb_row_ptr/sb_data row write to the skew buffer (sb_data[j] = column j)
//   sb_enable        skew buffer shift enable during drain
//   busy, tile_done, tile_count  status
// Optional build macro: SKEW_LOADER_PAD_EN (adds in_last and tile zero-padding).
module skew_loader #(
    parameter int DATA_WIDTH   = 8,
    parameter int ARRAY_SIZE   = 4,
    parameter int DRAIN_CYCLES = 2*ARRAY_SIZE-1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [DATA_WIDTH-1:0]  in_data,
`ifdef SKEW_LOADER_PAD_EN
    input  logic                          in_last,
`endif
    input  logic                          stall,
    output logic                          sb_write,
    output logic [$clog2(ARRAY_SIZE)-1:0] sb_row_ptr,
    output logic signed [DATA_WIDTH-1:0]  sb_data [ARRAY_SIZE-1:0],
    output logic                          sb_enable,
    output logic                          busy,
    output logic                          tile_done,
    output logic [15:0]                   tile_count
);

    localparam int CW  = $clog2(ARRAY_SIZE);
    localparam int DCW = $clog2(DRAIN_CYCLES+1);
    localparam logic [CW-1:0]  LAST_IDX   = CW'(ARRAY_SIZE-1);
    localparam logic [DCW-1:0] LAST_DRAIN = DCW'(DRAIN_CYCLES-1);

    typedef enum logic [1:0] {
        S_FILL    = 2'd0,
        S_LAST_WR = 2'd1,
        S_DRAIN   = 2'd2,
        S_PAD     = 2'd3   // zero-row writes after an early in_last
    } state_t;

    state_t                       state, state_nxt;
    logic [CW-1:0]                col, row;
    logic [DCW-1:0]               drain_cnt;
    logic signed [DATA_WIDTH-1:0] pack     [ARRAY_SIZE-1:0];
    logic signed [DATA_WIDTH-1:0] row_vals [ARRAY_SIZE-1:0];
    logic                         accept, row_end;

    // in_ready is also held low while reset is asserted so nothing is taken during reset.
    assign in_ready = (state == S_FILL) && rst;
    assign accept   = in_valid && in_ready;
    assign busy     = (state != S_FILL) || (col != '0) || (row != '0);

`ifdef SKEW_LOADER_PAD_EN
    assign row_end = (col == LAST_IDX) || in_last;
`else
    assign row_end = (col == LAST_IDX);
`endif

    // Row as it will be written: earlier slots from the packing register, the
    // current element in slot col, and zeros above it (only reachable on in_last).
    always_comb begin
        for (int j = 0; j < ARRAY_SIZE; j++) begin
            if (CW'(j) == col) begin
                row_vals[j] = in_data;
            end else if (CW'(j) > col) begin
                row_vals[j] = '0;
            end else begin
                row_vals[j] = pack[j];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FILL: begin
                if (accept && row_end) begin
                    if (row == LAST_IDX) begin
                        state_nxt = S_LAST_WR;
                    end
`ifdef SKEW_LOADER_PAD_EN
                    else if (in_last) begin
                        state_nxt = S_PAD;
                    end
`endif
                end
            end
            S_PAD: begin
                if (row == LAST_IDX) begin
                    state_nxt = S_LAST_WR;
                end
            end
            S_LAST_WR: state_nxt = S_DRAIN;
            S_DRAIN: begin
                if (sb_enable && (drain_cnt == LAST_DRAIN)) begin
                    state_nxt = S_FILL;
                end
            end
            default: state_nxt = S_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            col        <= '0;
            row        <= '0;
            drain_cnt  <= '0;
            sb_write   <= 1'b0;
            sb_row_ptr <= '0;
            sb_enable  <= 1'b0;
            tile_done  <= 1'b0;
            tile_count <= '0;
            for (int j = 0; j < ARRAY_SIZE; j++) begin
                pack[j]    <= '0;
                sb_data[j] <= '0;
            end
        end else begin
            sb_write  <= 1'b0;
            sb_enable <= 1'b0;
            tile_done <= 1'b0;
            case (state)
                S_FILL: begin
                    if (accept) begin
                        pack[col] <= in_data;
                        if (row_end) begin
                            // Row and col are powers-of-two wide, so the tile-end increment wraps to 0.
                            sb_write   <= 1'b1;
                            sb_row_ptr <= row;
                            for (int j = 0; j < ARRAY_SIZE; j++) begin
                                sb_data[j] <= row_vals[j];
                            end
                            col <= '0;
                            row <= row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                S_PAD: begin
                    sb_write   <= 1'b1;
                    sb_row_ptr <= row;
                    for (int j = 0; j < ARRAY_SIZE; j++) begin
                        sb_data[j] <= '0;
                    end
                    row <= row + 1'b1;
                end
                S_LAST_WR: begin
                    sb_enable <= !stall;
                end
                S_DRAIN: begin
                    if (sb_enable && (drain_cnt == LAST_DRAIN)) begin
                        drain_cnt  <= '0;
                        tile_done  <= 1'b1;
                        tile_count <= tile_count + 16'd1;
                    end else begin
                        if (sb_enable) begin
                            drain_cnt <= drain_cnt + 1'b1;
                        end
                        sb_enable <= !stall;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
